branch_predictor: RTL

- Bimodal branch predictor with branch target buffer for the 5-stage RV32I pipeline.
- IF stage: combinational lookup on the fetch PC returns predicted direction and target.
- EX stage: consumes the branch unit's resolved branch_taken plus the carried prediction, updates the table, and raises a mispredict redirect/flush to the PC mux and hazard logic.

---
 rtl/branch_predictor.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Bimodal branch predictor with a direct-mapped branch target buffer for the
//   5-stage RV32I pipeline. The IF stage gets a combinational prediction for
//   the fetch PC. The EX stage resolves the branch, trains the table and
//   requests a redirect/flush on a mispredict.
//
// Parameters
//   ENTRIES   number of table entries (power of two, >= 4)
//   TAG_BITS  stored tag width; tag = pc[IDX+TAG_BITS+1 : IDX+2]
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   if_pc             fetch PC to predict
//   pred_hit          valid entry whose tag matches if_pc
//   pred_taken        predicted taken
//   pred_target       predicted next PC (target if taken, else if_pc + 4)
//   ex_valid          EX holds a live instruction
//   ex_branch         EX instruction is a conditional branch
//   ex_pc             PC of the EX instruction
//   ex_branch_taken   resolved branch outcome
//   ex_target         computed branch target
//   ex_pred_taken     prediction carried with the EX instruction
//   ex_pred_target    predicted target carried with the EX instruction
//   mispredict        redirect/flush request this cycle
//   redirect_pc       correct next PC when mispredict = 1
//   perf_branches     (BP_PERF_CNT_EN only) count of resolved branches
//   perf_mispredicts  (BP_PERF_CNT_EN only) count of mispredict cycles
//
// Optional feature macro: BP_PERF_CNT_EN
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES  = 64,
    parameter int TAG_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
`endif
);

    localparam int IDX = $clog2(ENTRIES);

    logic                valid_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_q   [ENTRIES];
    logic [29:0]         tgt_q   [ENTRIES];
    logic [1:0]          ctr_q   [ENTRIES];

    logic [IDX-1:0]      if_idx;
    logic [IDX-1:0]      ex_idx;
    logic [TAG_BITS-1:0] if_tag;
    logic [TAG_BITS-1:0] ex_tag;
    logic                ex_hit;
    logic                upd_en;
    logic                alias_clr;

    assign if_idx = if_pc[IDX+1:2];
    assign if_tag = if_pc[IDX+TAG_BITS+1:IDX+2];
    assign ex_idx = ex_pc[IDX+1:2];
    assign ex_tag = ex_pc[IDX+TAG_BITS+1:IDX+2];

    assign ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign upd_en    = ex_valid && ex_branch;
    // A non-branch that was predicted taken aliased onto a BTB entry: drop it.
    assign alias_clr = ex_valid && !ex_branch && ex_pred_taken && ex_hit;

    // IF-stage lookup; reads the table before any same-cycle update lands.
    always_comb begin
        pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        pred_taken  = pred_hit && ctr_q[if_idx][1];
        pred_target = pred_taken ? {tgt_q[if_idx], 2'b00} : if_pc + 32'd4;
    end

    // EX-stage resolution.
    always_comb begin
        mispredict = 1'b0;
        if (ex_valid) begin
            if (ex_branch) begin
                mispredict = (ex_branch_taken != ex_pred_taken) ||
                             (ex_branch_taken && (ex_target != ex_pred_target));
            end else begin
                mispredict = ex_pred_taken;
            end
        end
        redirect_pc = (ex_branch && ex_branch_taken) ? ex_target : ex_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            if (ex_hit) begin
                if (ex_branch_taken) begin
                    if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    tgt_q[ex_idx] <= ex_target[31:2];
                end else if (ctr_q[ex_idx] != 2'b00) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_branch_taken) begin
                valid_q[ex_idx] <= 1'b1;
                tag_q[ex_idx]   <= ex_tag;
                tgt_q[ex_idx]   <= ex_target[31:2];
                ctr_q[ex_idx]   <= 2'b10;
            end
        end else if (alias_clr) begin
            valid_q[ex_idx] <= 1'b0;
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (upd_en)     perf_branches    <= perf_branches + 32'd1;
            if (mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule
